// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the A2D converter arbiter.
// Grant encoding, IR channel map and default timing parameters.
package a2d_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GUARD} state_t;

  localparam logic GNT_MOTION = 1'b0;
  localparam logic GNT_AUX    = 1'b1;

  // IR sensor pairs as wired on the converter mux
  localparam logic [2:0] CH_IR_INNER_L = 3'd1;
  localparam logic [2:0] CH_IR_INNER_R = 3'd0;
  localparam logic [2:0] CH_IR_MID_L   = 3'd4;
  localparam logic [2:0] CH_IR_MID_R   = 3'd2;
  localparam logic [2:0] CH_IR_OUTER_L = 3'd3;
  localparam logic [2:0] CH_IR_OUTER_R = 3'd7;

  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int GUARD_CYCLES_DEF   = 2;
  localparam int STARVE_LIMIT_DEF   = 3;

  // The aux sampler wins when it is alone or has waited out the starve limit.
  function automatic logic pick_aux(input logic pend0, input logic pend1,
                                    input logic starved);
    return pend1 && (!pend0 || starved);
  endfunction

endpackage

// File: rtl/a2d_arbiter_timer.sv
// Loadable down-counter with a terminal-count flag.
// Used for both the conversion timeout and the post-conversion guard.
module arb_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/a2d_arbiter.sv
// Arbitrates the single A2D converter between the motion controller (req0)
// and the auxiliary sampler (req1), with timeout and starvation protection.
//
// state | meaning
// IDLE  | no conversion; grant the next pending requester
// ISSUE | one-cycle start pulse to the converter, timeout timer loaded
// WAIT  | waiting for converter completion or timeout
// GUARD | converter CS recovery gap before the next grant
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_strt,
  input  logic [2:0]  req0_chnnl,
  input  logic        req1_strt,
  input  logic [2:0]  req1_chnnl,
  output logic        a2d_strt_cnv,
  output logic [2:0]  a2d_chnnl,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        cmplt0,
  output logic        cmplt1,
  output logic [11:0] res_out,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [2:0]    pch0_q, pch0_d;
  logic [2:0]    pch1_q, pch1_d;
  logic          gnt_q, gnt_d;
  logic [2:0]    chnl_q, chnl_d;
  logic [11:0]   res_q, res_d;
  logic [1:0]    cmplt_q, cmplt_d;
  logic          err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic tmo_load, tmo_en, tmo_done;
  logic grd_load, grd_en, grd_done;
  logic grant, win, fin, tmo_hit;

  arb_timer #(.WIDTH(TW)) u_tmo (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmo_load),
    .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
    .en_i       (tmo_en),
    .done_o     (tmo_done)
  );

  arb_timer #(.WIDTH(GW)) u_grd (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (grd_load),
    .load_val_i (GW'(GUARD_CYCLES - 1)),
    .en_i       (grd_en),
    .done_o     (grd_done)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pch0_d   = pch0_q;
    pch1_d   = pch1_q;
    gnt_d    = gnt_q;
    chnl_d   = chnl_q;
    res_d    = res_q;
    cmplt_d  = 2'b00;
    err_d    = err_q;
    starve_d = starve_q;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    grd_load = 1'b0;
    grd_en   = 1'b0;
    grant    = 1'b0;
    win      = GNT_MOTION;
    fin      = 1'b0;
    tmo_hit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant   = 1'b1;
          win     = pick_aux(pend_q[0], pend_q[1], starve_q == SW'(STARVE_LIMIT))
                    ? GNT_AUX : GNT_MOTION;
          gnt_d   = win;
          chnl_d  = (win == GNT_AUX) ? pch1_q : pch0_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        tmo_en = 1'b1;
        // a real completion beats a coincident timeout
        if (a2d_cnv_cmplt) begin
          res_d = a2d_res;
          fin   = 1'b1;
        end else if (tmo_done) begin
          res_d   = 12'h000;
          fin     = 1'b1;
          tmo_hit = 1'b1;
        end
        if (fin) begin
          cmplt_d[gnt_q] = 1'b1;
          grd_load       = 1'b1;
          state_d        = GUARD;
        end
      end
      GUARD: begin
        grd_en = 1'b1;
        if (grd_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a new request in its own completion cycle re-arms the latch
    if (req0_strt && (!pend_q[0] || (fin && gnt_q == GNT_MOTION))) begin
      pend_d[0] = 1'b1;
      pch0_d    = req0_chnnl;
    end else if (fin && gnt_q == GNT_MOTION) begin
      pend_d[0] = 1'b0;
    end
    if (req1_strt && (!pend_q[1] || (fin && gnt_q == GNT_AUX))) begin
      pend_d[1] = 1'b1;
      pch1_d    = req1_chnnl;
    end else if (fin && gnt_q == GNT_AUX) begin
      pend_d[1] = 1'b0;
    end

    if (!pend_q[1]) begin
      starve_d = '0;
    end else if (grant) begin
      if (win == GNT_AUX) starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end

    if (clr_err) err_d = 1'b0;
    else if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 2'b00;
      pch0_q   <= 3'b000;
      pch1_q   <= 3'b000;
      gnt_q    <= GNT_MOTION;
      chnl_q   <= 3'b000;
      res_q    <= 12'h000;
      cmplt_q  <= 2'b00;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pch0_q   <= pch0_d;
      pch1_q   <= pch1_d;
      gnt_q    <= gnt_d;
      chnl_q   <= chnl_d;
      res_q    <= res_d;
      cmplt_q  <= cmplt_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign a2d_strt_cnv = (state_q == ISSUE);
  assign a2d_chnnl    = chnl_q;
  assign cmplt0       = cmplt_q[0];
  assign cmplt1       = cmplt_q[1];
  assign res_out      = res_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: timestamp-based transaction model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_a2d_arbiter;
  import a2d_arb_pkg::*;

  localparam int TMO = 4096;
  localparam int GRD = 2;
  localparam int STV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_strt = 1'b0, req1_strt = 1'b0;
  logic [2:0]  req0_chnnl = 3'd0, req1_chnnl = 3'd0;
  logic        a2d_strt_cnv;
  logic [2:0]  a2d_chnnl;
  logic        a2d_cnv_cmplt = 1'b0;
  logic [11:0] a2d_res = 12'h000;
  logic        cmplt0, cmplt1;
  logic [11:0] res_out;
  logic        busy, timeout_err;
  logic        clr_err = 1'b0;

  always #5 clk = ~clk;

  a2d_arbiter #(.TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GRD), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_strt(req0_strt), .req0_chnnl(req0_chnnl),
    .req1_strt(req1_strt), .req1_chnnl(req1_chnnl),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res),
    .cmplt0(cmplt0), .cmplt1(cmplt1), .res_out(res_out),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen at the most recent rising edge
  logic        s_rst, s_cmplt, s_clr;
  logic        s_req[2];
  logic [2:0]  s_ch[2];
  logic [11:0] s_res;
  always @(posedge clk) begin
    s_rst = rst_n; s_cmplt = a2d_cnv_cmplt; s_res = a2d_res; s_clr = clr_err;
    s_req[0] = req0_strt; s_req[1] = req1_strt;
    s_ch[0] = req0_chnnl; s_ch[1] = req1_chnnl;
  end

  // Model: pending requests plus timestamps of the conversion in flight.
  int          k = 0;
  bit          m_pend[2];
  logic [2:0]  m_pch[2];
  bit          m_active;
  int          m_gnt, m_strt, m_free, m_starve;
  bit          m_err;
  logic [11:0] m_res;
  bit          m_cm[2];
  logic [2:0]  m_ch;
  int          fin, win, prev;
  bit          tmo;
  logic [11:0] nres;

  always @(negedge clk) begin
    k++;
    prev = k - 1;
    if (!rst_n || !s_rst) begin
      m_pend = '{0, 0}; m_pch[0] = 3'd0; m_pch[1] = 3'd0;
      m_active = 0; m_gnt = 0; m_strt = -100; m_free = 0; m_starve = 0;
      m_err = 0; m_res = 12'h000; m_cm = '{0, 0}; m_ch = 3'd0;
    end else begin
      fin = -1; tmo = 0; nres = 12'h000;
      if (m_active && prev > m_strt) begin
        if (s_cmplt) begin fin = m_gnt; nres = s_res; end
        else if (prev == m_strt + TMO) begin fin = m_gnt; tmo = 1; end
      end
      win = -1;
      if (!m_active && prev >= m_free && (m_pend[0] || m_pend[1]))
        win = (m_pend[1] && (!m_pend[0] || m_starve == STV)) ? 1 : 0;
      m_cm = '{0, 0};
      if (fin >= 0) begin
        m_cm[fin] = 1; m_res = nres; m_active = 0; m_free = k + GRD;
      end
      if (s_clr) m_err = 0;
      else if (tmo) m_err = 1;
      if (!m_pend[1] || win == 1) m_starve = 0;
      else if (win == 0 && m_starve < STV) m_starve++;
      if (win >= 0) begin
        m_active = 1; m_gnt = win; m_strt = k; m_ch = m_pch[win];
      end
      for (int n = 0; n < 2; n++) begin
        if (s_req[n] && (!m_pend[n] || fin == n)) begin
          m_pend[n] = 1; m_pch[n] = s_ch[n];
        end else if (fin == n) begin
          m_pend[n] = 0;
        end
      end
    end
    chk("strt_cnv", 32'(a2d_strt_cnv), 32'(m_active && k == m_strt));
    chk("chnnl", 32'(a2d_chnnl), 32'(m_ch));
    chk("cmplt0", 32'(cmplt0), 32'(m_cm[0]));
    chk("cmplt1", 32'(cmplt1), 32'(m_cm[1]));
    chk("res_out", 32'(res_out), 32'(m_res));
    chk("busy", 32'(busy), 32'(m_active || k < m_free));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  end

  // Converter stand-in and stimulus helpers
  bit conv_auto = 0, spur_en = 0;
  int conv_fixed = 0, cnv_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    req0_strt = 0; req1_strt = 0; clr_err = 0; a2d_cnv_cmplt = 0;
    if (!rst_n) begin
      cnv_cnt = 0;
    end else begin
      if (cnv_cnt > 0) begin
        cnv_cnt--;
        if (cnv_cnt == 0) begin a2d_cnv_cmplt = 1; a2d_res = 12'($urandom); end
      end else if (spur_en && $urandom_range(0, 39) == 0) begin
        a2d_cnv_cmplt = 1; a2d_res = 12'($urandom);
      end
      if (conv_auto && a2d_strt_cnv)
        cnv_cnt = (conv_fixed > 0) ? conv_fixed : int'($urandom_range(1, 12));
    end
  endtask

  task automatic wait_strt(input int maxc, output int n);
    n = 0;
    while (!a2d_strt_cnv && n < maxc) begin tick(); n++; end
    chk("strt_seen", 32'(a2d_strt_cnv), 32'd1);
  endtask

  task automatic wait_cmplt(input bit which, input int maxc, output int n);
    n = 0;
    while (!(which ? cmplt1 : cmplt0) && n < maxc) begin tick(); n++; end
    chk("cmplt_seen", 32'(which ? cmplt1 : cmplt0), 32'd1);
  endtask

  int n;
  logic [2:0] seq[5];
  logic [2:0] exp_seq[5];

  initial begin
    repeat (3) tick();
    rst_n = 1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);

    // Single motion request, standard latency and routing
    req0_strt = 1; req0_chnnl = CH_IR_MID_L;
    wait_strt(10, n);
    chk("t1_lat", 32'(n), 32'd2);
    chk("t1_ch", 32'(a2d_chnnl), 32'd4);
    tick(); tick();
    a2d_cnv_cmplt = 1; a2d_res = 12'hA5C;
    tick();
    chk("t1_cmplt0", 32'(cmplt0), 32'd1);
    chk("t1_cmplt1", 32'(cmplt1), 32'd0);
    chk("t1_res", 32'(res_out), 32'hA5C);
    repeat (5) tick();

    // Simultaneous requests: motion first, aux after the guard gap
    req0_strt = 1; req0_chnnl = CH_IR_INNER_L;
    req1_strt = 1; req1_chnnl = CH_IR_OUTER_R;
    wait_strt(10, n);
    chk("t2_lat", 32'(n), 32'd2);
    chk("t2_ch0", 32'(a2d_chnnl), 32'd1);
    tick();
    a2d_cnv_cmplt = 1; a2d_res = 12'h111;
    tick();
    chk("t2_cmplt0", 32'(cmplt0), 32'd1);
    chk("t2_res0", 32'(res_out), 32'h111);
    wait_strt(10, n);
    chk("t2_gap", 32'(n), 32'd3);
    chk("t2_ch1", 32'(a2d_chnnl), 32'd7);
    tick();
    a2d_cnv_cmplt = 1; a2d_res = 12'h222;
    tick();
    chk("t2_cmplt1", 32'(cmplt1), 32'd1);
    chk("t2_cmplt0_low", 32'(cmplt0), 32'd0);
    chk("t2_res1", 32'(res_out), 32'h222);
    repeat (5) tick();

    // Starvation: continuous motion requests with aux pending
    conv_auto = 1; conv_fixed = 3;
    req0_strt = 1; req0_chnnl = 3'd2;
    req1_strt = 1; req1_chnnl = 3'd6;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      req0_strt = 1; req0_chnnl = 3'd2;
      if (a2d_strt_cnv) begin seq[n] = a2d_chnnl; n++; end
    end
    exp_seq = '{3'd2, 3'd2, 3'd2, 3'd6, 3'd2};
    chk("t3_grants", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    repeat (30) tick();
    conv_fixed = 0; conv_auto = 0;
    repeat (5) tick();

    // Ignored re-request while pending; re-request in the completion cycle
    req0_strt = 1; req0_chnnl = 3'd2;
    tick();
    req0_strt = 1; req0_chnnl = 3'd5;
    wait_strt(10, n);
    chk("t5_lat", 32'(n), 32'd1);
    chk("t5_ch_kept", 32'(a2d_chnnl), 32'd2);
    tick();
    a2d_cnv_cmplt = 1; a2d_res = 12'h333;
    req0_strt = 1; req0_chnnl = 3'd7;
    tick();
    chk("t5_cmplt0", 32'(cmplt0), 32'd1);
    wait_strt(10, n);
    chk("t5_gap", 32'(n), 32'd3);
    chk("t5_ch_new", 32'(a2d_chnnl), 32'd7);
    tick();
    a2d_cnv_cmplt = 1; a2d_res = 12'h444;
    repeat (6) tick();

    // Dead converter: timeout, error flag, clear, recovery
    req1_strt = 1; req1_chnnl = CH_IR_OUTER_L;
    wait_strt(10, n);
    wait_cmplt(1, TMO + 100, n);
    chk("t4_tmo_lat", 32'(n), 32'(TMO + 1));
    chk("t4_res", 32'(res_out), 32'h000);
    chk("t4_err", 32'(timeout_err), 32'd1);
    tick();
    clr_err = 1;
    tick();
    chk("t4_err_clr", 32'(timeout_err), 32'd0);
    conv_auto = 1;
    req0_strt = 1; req0_chnnl = CH_IR_INNER_R;
    wait_strt(10, n);
    chk("t4_rec_lat", 32'(n), 32'd2);
    wait_cmplt(0, 20, n);
    chk("t4_rec_err", 32'(timeout_err), 32'd0);
    repeat (6) tick();
    conv_auto = 0;

    // Reset during WAIT
    req0_strt = 1; req0_chnnl = 3'd4;
    wait_strt(10, n);
    tick(); tick();
    #1 rst_n = 0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_strt", 32'(a2d_strt_cnv), 32'd0);
    chk("t6_ch", 32'(a2d_chnnl), 32'd0);
    chk("t6_res", 32'(res_out), 32'd0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_cmplt", 32'(cmplt0 | cmplt1), 32'd0);
    end
    req0_strt = 1; req0_chnnl = 3'd6;
    wait_strt(10, n);
    chk("t6_lat", 32'(n), 32'd2);
    chk("t6_ch_new", 32'(a2d_chnnl), 32'd6);
    conv_auto = 1;
    repeat (20) tick();

    // Randomized traffic against the model
    spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 1499) == 0) rst_n = 0;
      req0_strt = ($urandom_range(0, 3) == 0);
      req0_chnnl = 3'($urandom);
      req1_strt = ($urandom_range(0, 3) == 0);
      req1_chnnl = 3'($urandom);
      clr_err = ($urandom_range(0, 63) == 0);
    end
    spur_en = 0;
    rst_n = 1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
